// File: rtl/quadrature_mixer.sv
// quadrature_mixer
//   Mixes a 1-bit RF sample stream against a signed sine/cosine local
//   oscillator. The RF bit passes through a short register chain. The last
//   stage picks, per update, whether the LO samples are passed through or
//   negated (the mode input can swap that choice, force a bypass or mute
//   the outputs). Negating the most negative LO value overflows: it either
//   clamps or wraps, and each update that overflows bumps a sticky counter.
//
// Ports
//   clk            single clock
//   rst            synchronous reset, active high
//   en             output update enable
//   mode[1:0]      00 mix, 01 inverted mix, 10 LO bypass, 11 mute
//   rf_in          1-bit RF sample
//   lo_valid       qualifies sinewave_in / cosinewave_in
//   sinewave_in    signed sine LO sample   (INPUT_WIDTH)
//   cosinewave_in  signed cosine LO sample (INPUT_WIDTH)
//   sat_clr        clears sat_count
//   rf_out         rf_in delayed one cycle
//   sinewave_out   signed mixed I result   (INPUT_WIDTH)
//   cosinewave_out signed mixed Q result   (INPUT_WIDTH)
//   out_valid      outputs updated this cycle
//   sat_count      sticky count of negation-overflow updates (CNT_WIDTH)
module quadrature_mixer #(
  parameter int INPUT_WIDTH    = 12,
  parameter int RF_SYNC_STAGES = 2,
  parameter int SATURATE       = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic                          rf_in,
  input  logic                          lo_valid,
  input  logic signed [INPUT_WIDTH-1:0] sinewave_in,
  input  logic signed [INPUT_WIDTH-1:0] cosinewave_in,
  input  logic                          sat_clr,
  output logic                          rf_out,
  output logic signed [INPUT_WIDTH-1:0] sinewave_out,
  output logic signed [INPUT_WIDTH-1:0] cosinewave_out,
  output logic                          out_valid,
  output logic [CNT_WIDTH-1:0]          sat_count
);

  typedef enum logic [1:0] {
    MODE_MIX    = 2'b00,
    MODE_INV    = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_MUTE   = 2'b11
  } mode_e;

  localparam logic [INPUT_WIDTH-1:0] S_MIN = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic [INPUT_WIDTH-1:0] S_MAX = {1'b0, {(INPUT_WIDTH-1){1'b1}}};

  // Returns {overflow, result} for one LO channel.
  function automatic logic [INPUT_WIDTH:0] mix_chan(
    input logic [INPUT_WIDTH-1:0] x,
    input logic                   negate,
    input logic                   mute
  );
    logic [INPUT_WIDTH-1:0] neg_x;
    neg_x = '0 - x;
    if (mute) begin
      mix_chan = '0;
    end else if (!negate) begin
      mix_chan = {1'b0, x};
    end else if (x == S_MIN) begin
      mix_chan = {1'b1, (SATURATE != 0) ? S_MAX : S_MIN};
    end else begin
      mix_chan = {1'b0, neg_x};
    end
  endfunction

  logic [RF_SYNC_STAGES-1:0] rf_chain_q, rf_chain_d;
  logic [INPUT_WIDTH-1:0]    sin_q, sin_d;
  logic [INPUT_WIDTH-1:0]    cos_q, cos_d;
  logic                      valid_q, valid_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  mode_e                     mode_s;
  logic                      rf_sel;
  logic                      upd;
  logic                      negate;
  logic                      mute;
  logic [INPUT_WIDTH:0]      sin_mix, cos_mix;
  logic                      ovf_evt;

  assign mode_s = mode_e'(mode);
  assign rf_sel = rf_chain_q[RF_SYNC_STAGES-1];
  assign upd    = en & lo_valid;

  always_comb begin
    // Stage 0 takes rf_in; the oldest sample falls off the top.
    rf_chain_d = RF_SYNC_STAGES'({rf_chain_q, rf_in});

    negate = 1'b0;
    mute   = 1'b0;
    unique case (mode_s)
      MODE_MIX:    negate = rf_sel;
      MODE_INV:    negate = ~rf_sel;
      MODE_BYPASS: negate = 1'b0;
      MODE_MUTE:   mute   = 1'b1;
      default:     negate = 1'b0;
    endcase

    sin_mix = mix_chan(sinewave_in, negate, mute);
    cos_mix = mix_chan(cosinewave_in, negate, mute);
    ovf_evt = upd & (sin_mix[INPUT_WIDTH] | cos_mix[INPUT_WIDTH]);

    sin_d   = sin_q;
    cos_d   = cos_q;
    valid_d = upd;
    if (upd) begin
      sin_d = sin_mix[INPUT_WIDTH-1:0];
      cos_d = cos_mix[INPUT_WIDTH-1:0];
    end

    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (ovf_evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_chain_q <= '1;
      sin_q      <= '0;
      cos_q      <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rf_chain_q <= rf_chain_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_out         = rf_chain_q[0];
  assign sinewave_out   = sin_q;
  assign cosinewave_out = cos_q;
  assign out_valid      = valid_q;
  assign sat_count      = cnt_q;

endmodule

// File: tb/tb_quadrature_mixer.sv
// Scoreboard bench for quadrature_mixer. Two instances share stimulus:
//   dut 0: 3 RF stages, saturating, 4-bit counter
//   dut 1: 2 RF stages, wrapping,    16-bit counter
module tb_quadrature_mixer;

  localparam int W    = 12;
  localparam int SMAX = 2047;
  localparam int SMIN = -2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic               rf_in = 1'b0;
  logic               lo_valid = 1'b0;
  logic signed [W-1:0] sin_in = '0;
  logic signed [W-1:0] cos_in = '0;
  logic               sat_clr = 1'b0;

  logic               a_rfout, a_valid, b_rfout, b_valid;
  logic signed [W-1:0] a_sin, a_cos, b_sin, b_cos;
  logic [3:0]         a_cnt;
  logic [15:0]        b_cnt;

  quadrature_mixer #(.INPUT_WIDTH(W), .RF_SYNC_STAGES(3), .SATURATE(1), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rf_in(rf_in), .lo_valid(lo_valid),
    .sinewave_in(sin_in), .cosinewave_in(cos_in), .sat_clr(sat_clr),
    .rf_out(a_rfout), .sinewave_out(a_sin), .cosinewave_out(a_cos),
    .out_valid(a_valid), .sat_count(a_cnt));

  quadrature_mixer #(.INPUT_WIDTH(W), .RF_SYNC_STAGES(2), .SATURATE(0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .rf_in(rf_in), .lo_valid(lo_valid),
    .sinewave_in(sin_in), .cosinewave_in(cos_in), .sat_clr(sat_clr),
    .rf_out(b_rfout), .sinewave_out(b_sin), .cosinewave_out(b_cos),
    .out_valid(b_valid), .sat_count(b_cnt));

  function automatic int cfg_stages(input int c);
    return (c == 0) ? 3 : 2;
  endfunction
  function automatic int cfg_sat(input int c);
    return (c == 0) ? 1 : 0;
  endfunction
  function automatic int cfg_cmax(input int c);
    return (c == 0) ? 15 : 65535;
  endfunction

  // Reference behaviour of one channel from the mixing rules.
  function automatic int mix_ref(input int x, input int md, input bit sel,
                                 input int sat, output bit ovf);
    bit neg;
    ovf = 1'b0;
    if (md == 3) return 0;
    neg = (md == 0 && sel) || (md == 1 && !sel);
    if (!neg) return x;
    if (-x > SMAX) begin
      ovf = 1'b1;
      return (sat != 0) ? SMAX : SMIN;
    end
    return -x;
  endfunction

  typedef struct { int s; int c; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int   m_sin[2], m_cos[2], m_cnt[2], m_fill[2];
  bit   m_valid[2], m_rfout[2];
  logic [7:0] m_hist[2];   // bit k = rf_in sampled k+1 edges ago
  bit   started = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int c);
    bit sel, ov_s, ov_c;
    int s, co;
    exp_t e;
    if (rst) begin
      m_sin[c] = 0; m_cos[c] = 0; m_cnt[c] = 0; m_valid[c] = 1'b0;
      m_rfout[c] = 1'b1; m_fill[c] = 0; m_hist[c] = '0;
      if (c == 0) q0.delete(); else q1.delete();
      return;
    end
    sel = (m_fill[c] >= cfg_stages(c)) ? m_hist[c][cfg_stages(c)-1] : 1'b1;
    ov_s = 1'b0; ov_c = 1'b0;
    m_valid[c] = en && lo_valid;
    if (en && lo_valid) begin
      s  = mix_ref(int'(sin_in), int'(mode), sel, cfg_sat(c), ov_s);
      co = mix_ref(int'(cos_in), int'(mode), sel, cfg_sat(c), ov_c);
      m_sin[c] = s; m_cos[c] = co;
      e.s = s; e.c = co;
      if (c == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (sat_clr) m_cnt[c] = 0;
    else if ((ov_s || ov_c) && m_cnt[c] < cfg_cmax(c)) m_cnt[c]++;
    m_hist[c] = {m_hist[c][6:0], rf_in};
    if (m_fill[c] < 8) m_fill[c]++;
    m_rfout[c] = rf_in;
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) model_step(c);
    started = 1'b1;
  end

  task automatic check_dut(input int c, input bit v, input int s, input int co,
                           input int cnt, input bit rfo);
    exp_t e;
    bit   have;
    string tag;
    tag = $sformatf("[%0d]", c);
    chk({"out_valid", tag}, int'(v), int'(m_valid[c]));
    chk({"rf_out", tag}, int'(rfo), int'(m_rfout[c]));
    chk({"sat_count", tag}, cnt, m_cnt[c]);
    if (v) begin
      have = (c == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        chk({"unexpected_output", tag}, 1, 0);
      end else begin
        e = (c == 0) ? q0.pop_front() : q1.pop_front();
        chk({"sin_out", tag}, s, e.s);
        chk({"cos_out", tag}, co, e.c);
      end
    end else begin
      chk({"sin_hold", tag}, s, m_sin[c]);
      chk({"cos_hold", tag}, co, m_cos[c]);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_dut(0, a_valid, int'(a_sin), int'(a_cos), int'(a_cnt), a_rfout);
      check_dut(1, b_valid, int'(b_sin), int'(b_cos), int'(b_cnt), b_rfout);
    end
  end

  task automatic step(input bit r, input bit e, input bit l, input int md,
                      input bit rf, input int s, input int co, input bit clr);
    rst = r; en = e; lo_valid = l; mode = 2'(md); rf_in = rf;
    sin_in = W'(s); cos_in = W'(co); sat_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, then chain fill with rf_in=0: first updates still see 1s.
    repeat (3) step(1, 1, 1, 0, 0, 100, -200, 1);
    repeat (6) step(0, 1, 1, 0, 0, 100, -200, 0);
    // Single-cycle low pulse on rf_in.
    repeat (4) step(0, 1, 1, 0, 1, 300, 50, 0);
    step(0, 1, 1, 0, 0, 300, 50, 0);
    repeat (6) step(0, 1, 1, 0, 1, 300, 50, 0);
    // Overflow burst with rf_sel=1: counter saturation on the 4-bit instance.
    repeat (20) step(0, 1, 1, 0, 1, SMIN, SMIN, 0);
    step(0, 1, 1, 0, 1, SMIN, SMIN, 1);
    repeat (3) step(0, 1, 1, 0, 1, SMIN, SMIN, 0);
    // One overflowing channel only, then inverted mode overflow.
    step(0, 1, 1, 0, 1, SMIN, 7, 0);
    repeat (4) step(0, 1, 1, 1, 0, 5, SMIN, 0);
    // lo_valid gap: outputs hold.
    step(0, 1, 1, 0, 1, 123, -45, 0);
    step(0, 1, 0, 0, 1, 999, 999, 0);
    step(0, 1, 1, 0, 1, 321, -54, 0);
    step(0, 0, 1, 0, 1, 888, 888, 0);
    // Bypass then mute with the most negative input.
    repeat (2) step(0, 1, 1, 2, 1, SMIN, SMIN, 0);
    repeat (2) step(0, 1, 1, 3, 1, SMIN, 77, 0);
    // Reset mid-burst.
    repeat (3) step(0, 1, 1, 0, 1, SMIN, SMIN, 0);
    step(1, 1, 1, 0, 0, SMIN, SMIN, 0);
    repeat (5) step(0, 1, 1, 0, 0, SMIN, 9, 0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 97) == 0, ($urandom % 8) != 0, ($urandom % 4) != 0,
           int'($urandom % 4), 1'($urandom % 2),
           (($urandom % 6) == 0) ? SMIN : int'($urandom_range(0, 4095)) - 2048,
           (($urandom % 6) == 0) ? SMIN : int'($urandom_range(0, 4095)) - 2048,
           ($urandom % 40) == 0);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain[0]", q0.size(), 0);
    chk("drain[1]", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_mixer.md
QUADRATURE_MIXER -- requirements
Module: quadrature_mixer

Interface
REQ-001 Parameter INPUT_WIDTH, default 12: width of the signed LO inputs and mixed outputs; legal range 4..24.
REQ-002 Parameter RF_SYNC_STAGES, default 2: depth of the rf_in delay chain before the mix decision; legal range 1..4.
REQ-003 Parameter SATURATE, default 1: 1 clamps negation overflow; 0 wraps two's-complement.
REQ-004 Parameter CNT_WIDTH, default 16: width of the overflow event counter.
REQ-005 clk  input  1  Single clock for all logic.
REQ-006 rst  input  1  Synchronous reset, active-high.
REQ-007 en  input  1  Output update enable.
REQ-008 mode  input  2  Mixing mode: 00 mix, 01 inverted mix, 10 LO bypass, 11 mute.
REQ-009 rf_in  input  1  1-bit RF (comparator / sigma-delta) sample.
REQ-010 lo_valid  input  1  Qualifies sinewave_in and cosinewave_in this cycle.
REQ-011 sinewave_in  input  INPUT_WIDTH  Signed sine LO sample.
REQ-012 cosinewave_in  input  INPUT_WIDTH  Signed cosine LO sample.
REQ-013 sat_clr  input  1  Clears sat_count.
REQ-014 rf_out  output  1  rf_in delayed by exactly 1 cycle (first chain stage).
REQ-015 sinewave_out  output  INPUT_WIDTH  Signed mixed sine (I) result.
REQ-016 cosinewave_out  output  INPUT_WIDTH  Signed mixed cosine (Q) result.
REQ-017 out_valid  output  1  Sinewave_out/cosinewave_out updated this cycle.
REQ-018 sat_count  output  CNT_WIDTH  Number of negation overflow events.

Function
REQ-019 rf_in SHALL be shifted into an RF_SYNC_STAGES-deep register chain every clock, independent of en, lo_valid and mode; rf_sel = last stage.
REQ-020 rf_out SHALL equal chain stage 1 (rf_in delayed 1 cycle) for every RF_SYNC_STAGES value.
REQ-021 Update condition: en=1 and lo_valid=1; outputs register 1 cycle after the qualifying inputs, and out_valid SHALL be 1 in exactly that cycle.
REQ-022 When the update condition is false, sinewave_out/cosinewave_out SHALL hold their values and out_valid SHALL be 0.
REQ-023 mode 00: rf_sel=0 -> outputs = inputs; rf_sel=1 -> outputs = negated inputs.
REQ-024 mode 01: rf_sel=1 -> outputs = inputs; rf_sel=0 -> outputs = negated inputs.
REQ-025 mode 10: outputs = inputs regardless of rf_sel; no negation, no overflow events.
REQ-026 mode 11: outputs = 0 regardless of inputs; out_valid still follows REQ-021.
REQ-027 Negation overflow: input equals -2^(INPUT_WIDTH-1) while negation is selected; handled per channel.
REQ-028 SATURATE=1: overflowing channel output SHALL be 2^(INPUT_WIDTH-1)-1; SATURATE=0: output SHALL be -2^(INPUT_WIDTH-1) (wrap).
REQ-029 One overflow event SHALL be counted per update cycle in which either or both channels overflow, for either SATURATE value.
REQ-030 sat_count SHALL stick at 2^CNT_WIDTH-1 and never wrap.
REQ-031 sat_clr=1 SHALL set sat_count to 0 next cycle; sat_clr wins over a simultaneous overflow event.
REQ-032 A mode change SHALL take effect on the first qualifying update sampled with the new mode; there is no pipeline flush.

Reset
REQ-033 During rst=1: all RF chain stages = 1, rf_out = 1, sinewave_out = 0, cosinewave_out = 0, out_valid = 0, sat_count = 0.
REQ-034 rst SHALL override en, lo_valid, sat_clr and mode, including mid-stream; the first update after release SHALL use a chain refilled from 1s.

Verification
REQ-035 Reset then rf_in=0 held 3 cycles, mode=00, sin=100, cos=-200, en=lo_valid=1 -> after the chain fills, out_valid=1 with sin_out=100, cos_out=-200; while rf_sel is still 1 from reset, outputs are -100/200.
REQ-036 RF_SYNC_STAGES=3, single-cycle rf_in pulse 1->0->1 -> rf_out low exactly 1 cycle later, output sign flips exactly 3+1 cycles after the pulse.
REQ-037 W=12, SATURATE=1, rf_sel=1, sin=-2048, cos=-2048, 3 qualifying cycles -> outputs 2047/2047, sat_count=3; repeat with SATURATE=0 -> outputs -2048, sat_count=3.
REQ-038 lo_valid toggling 1,0,1 with en=1 -> out_valid pattern 1,0,1 one cycle later; outputs hold across the gap.
REQ-039 mode sweep 10 then 11 with sin=-2048, rf_sel=1 -> bypass gives -2048 with no count increment; mute gives 0/0.
REQ-040 CNT_WIDTH=4, 20 overflow cycles -> sat_count=15; sat_clr asserted together with an overflow -> sat_count=0; reset asserted mid-burst -> all outputs at REQ-033 values next cycle.
